// File: rtl/calc_sequencer.sv
// Calculator control core: switch sync/edge detect, BCD operands,
// iterative add/sub/mul/div engine and double-dabble conversion.
module calc_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] sw,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       dot,
    output logic       neg,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, CONV, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t state, nxt;
    op_t    op_r;

    logic [SYNC_STAGES-1:0][8:0] sync;
    logic [8:0]  prev, rise, pick;
    logic        accept, show_p, neg_p, err_p, exec_last, ge;
    logic [3:0]  a1, a0, b1, b0, cnt;
    logic [6:0]  av, bv, a_bin, b_bin, r, dv;
    logic [7:0]  sh;
    logic [13:0] res, mc;
    logic [6:0]  mp;
    logic [15:0] bcd;
    logic [14:0] adj;

    function automatic logic [3:0] inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Add-3 correction for every nibble >= 5; the top bit shifts out.
    function automatic logic [14:0] dd_adj(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < 4; i++)
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        return t[14:0];
    endfunction

    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign accept = (state == IDLE) && (|rise);
    assign av = 7'(a1) * 7'd10 + 7'(a0);
    assign bv = 7'(b1) * 7'd10 + 7'(b0);
    assign sh = {r, res[6]};
    assign ge = (b_bin != 7'd0) && (sh >= {1'b0, b_bin});
    assign dv = 7'(sh - {1'b0, b_bin});
    assign adj = dd_adj(bcd);
    assign err_p = (op_r == OP_DIV) && (b_bin == 7'd0);
    assign exec_last = (op_r == OP_ADD) || (op_r == OP_SUB) || (cnt == 4'd6);

    always_comb begin
        pick = '0;
        for (int i = 0; i < 9; i++)
            if (rise[i]) begin
                pick = '0;
                pick[i] = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= '0;
        end else begin
            sync[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (accept && (|pick[4:1])) nxt = LOAD;
            LOAD:    nxt = EXEC;
            EXEC:    if (exec_last) nxt = CONV;
            CONV:    if (cnt == 4'd13) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {a1, a0, b1, b0} <= '0;
            op_r   <= OP_ADD;
            show_p <= 1'b0;
            neg_p  <= 1'b0;
            a_bin  <= '0;
            b_bin  <= '0;
            cnt    <= '0;
            res    <= '0;
            mc     <= '0;
            mp     <= '0;
            r      <= '0;
            bcd    <= '0;
        end else begin
            show_p <= 1'b0;
            if (accept) begin
                unique case (1'b1)
                    pick[8]: a1 <= inc(a1);
                    pick[7]: a0 <= inc(a0);
                    pick[6]: b1 <= inc(b1);
                    pick[5]: b0 <= inc(b0);
                    pick[4]: op_r <= OP_SUB;
                    pick[3]: op_r <= OP_DIV;
                    pick[2]: op_r <= OP_ADD;
                    pick[1]: op_r <= OP_MUL;
                    default: ;
                endcase
                show_p <= (|pick[8:5]) | pick[0];
            end
            unique case (state)
                LOAD: begin
                    a_bin <= av;
                    b_bin <= bv;
                    cnt   <= '0;
                    bcd   <= '0;
                    neg_p <= 1'b0;
                    mc    <= 14'(av);
                    mp    <= bv;
                    r     <= '0;
                    res   <= (op_r == OP_DIV) ? 14'(av) : 14'd0;
                end
                EXEC: begin
                    cnt <= exec_last ? 4'd0 : cnt + 4'd1;
                    unique case (op_r)
                        OP_ADD: res <= 14'(a_bin) + 14'(b_bin);
                        OP_SUB: begin
                            res <= (a_bin >= b_bin) ? 14'(a_bin - b_bin)
                                                    : 14'(b_bin - a_bin);
                            neg_p <= a_bin < b_bin;
                        end
                        OP_MUL: begin
                            if (mp[0]) res <= res + mc;
                            mc <= {mc[12:0], 1'b0};
                            mp <= {1'b0, mp[6:1]};
                        end
                        OP_DIV: begin
                            r   <= ge ? dv : sh[6:0];
                            res <= {res[13:7], res[5:0], ge};
                        end
                        default: ;
                    endcase
                end
                CONV: begin
                    cnt <= cnt + 4'd1;
                    bcd <= {adj, res[13]};
                    res <= {res[12:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {digit1, digit2, digit3, digit4} <= '0;
            dot  <= 1'b1;
            neg  <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b0;
        end else begin
            if (show_p) begin
                {digit1, digit2, digit3, digit4} <= {a1, a0, b1, b0};
                dot <= 1'b1;
                neg <= 1'b0;
                err <= 1'b0;
            end else if (state == DONE) begin
                {digit1, digit2, digit3, digit4} <= bcd;
                dot <= 1'b0;
                neg <= neg_p;
                err <= err_p;
            end
            if (state == LOAD)      busy <= 1'b1;
            else if (state == DONE) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: operand entry, all four ops,
// timing, arbitration and mid-sequence reset.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] sw = '0;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       dot, neg, err, busy;

    int n_run = 0;
    int n_fail = 0;

    logic [3:0]  ma1 = 0, ma0 = 0, mb1 = 0, mb0 = 0;
    logic [15:0] cur_d = '0;
    logic        cur_dot = 1'b1, cur_neg = 1'b0, cur_err = 1'b0;

    always #5 clk = ~clk;

    calc_sequencer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sw(sw),
        .digit1(digit1), .digit2(digit2),
        .digit3(digit3), .digit4(digit4),
        .dot(dot), .neg(neg), .err(err), .busy(busy)
    );

    wire [15:0] disp = {digit1, digit2, digit3, digit4};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] minc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    task automatic operand_view();
        cur_d = {ma1, ma0, mb1, mb0};
        cur_dot = 1'b1;
        cur_neg = 1'b0;
        cur_err = 1'b0;
    endtask

    task automatic check_view(input string tag);
        check({tag, "_digits"}, 32'(disp), 32'(cur_d));
        check({tag, "_dot"}, 32'(dot), 32'(cur_dot));
        check({tag, "_neg"}, 32'(neg), 32'(cur_neg));
        check({tag, "_err"}, 32'(err), 32'(cur_err));
    endtask

    task automatic press(input int idx, input int times);
        for (int k = 0; k < times; k++) begin
            sw[idx] = 1'b1;
            tick(4);
            sw[idx] = 1'b0;
            tick(3);
            case (idx)
                8: ma1 = minc(ma1);
                7: ma0 = minc(ma0);
                6: mb1 = minc(mb1);
                5: mb0 = minc(mb0);
                default: ;
            endcase
            operand_view();
        end
    endtask

    task automatic run_op(input string tag, input int idx, input int lat,
                          input logic [15:0] exp_d, input logic exp_neg,
                          input logic exp_err, input int intr);
        sw[idx] = 1'b1;
        tick(3);
        check({tag, "_busy_pre"}, 32'(busy), 32'd0);
        tick(1);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        for (int k = 5; k <= 2 + lat; k++) begin
            tick(1);
            if (k == 6) sw[idx] = 1'b0;
            if (intr >= 0 && k == 10) sw[intr] = 1'b1;
            if (intr >= 0 && k == 14) sw[intr] = 1'b0;
        end
        check({tag, "_busy_hold"}, 32'(busy), 32'd1);
        check({tag, "_held"}, 32'(disp), 32'(cur_d));
        tick(1);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        cur_d = exp_d;
        cur_dot = 1'b0;
        cur_neg = exp_neg;
        cur_err = exp_err;
        check_view(tag);
        tick(3);
    endtask

    initial begin
        tick(2);
        cur_d = '0;
        check_view("reset");
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick(2);

        press(8, 9);
        press(7, 9);
        press(6, 9);
        press(5, 9);
        check_view("entry_9999");
        press(5, 1);
        check_view("wrap_9990");
        press(5, 9);

        run_op("add99", 2, 17, 16'h0198, 1'b0, 1'b0, -1);
        run_op("mul99", 1, 23, 16'h9801, 1'b0, 1'b0, -1);
        run_op("sub99", 4, 17, 16'h0000, 1'b0, 1'b0, -1);
        run_op("div99", 3, 23, 16'h0001, 1'b0, 1'b0, -1);
        press(0, 1);
        check_view("show99");

        press(8, 4);
        press(7, 3);
        press(5, 9);
        check_view("show3298");
        run_op("sub32", 4, 17, 16'h0066, 1'b1, 1'b0, -1);
        run_op("div32", 3, 23, 16'h0000, 1'b0, 1'b0, -1);
        run_op("mul32", 1, 23, 16'h3136, 1'b0, 1'b0, -1);
        run_op("mul_intr", 1, 23, 16'h3136, 1'b0, 1'b0, 4);

        press(6, 1);
        press(5, 2);
        run_op("div0", 3, 23, 16'h0000, 1'b0, 1'b1, -1);
        press(0, 1);
        check_view("show3200");

        sw[8] = 1'b1;
        sw[2] = 1'b1;
        tick(4);
        ma1 = minc(ma1);
        operand_view();
        check_view("arb");
        check("arb_busy", 32'(busy), 32'd0);
        tick(4);
        check("arb_busy_late", 32'(busy), 32'd0);
        sw[8] = 1'b0;
        sw[2] = 1'b0;
        tick(4);

        sw[1] = 1'b1;
        tick(13);
        check("rst_busy_pre", 32'(busy), 32'd1);
        sw[1] = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digits", 32'(disp), 32'd0);
        check("rst_dot", 32'(dot), 32'd1);
        tick(2);
        reset = 1'b1;
        {ma1, ma0, mb1, mb0} = '0;
        tick(3);
        press(0, 1);
        check_view("show_after_rst");
        check("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control and sequencing core of the four-digit calculator. Takes the nine raw operation/entry switches, synchronizes and edge-detects them, and keeps the two 2-digit BCD operands. It schedules a shared iterative arithmetic unit (add, subtract, multiply, divide) followed by binary-to-BCD conversion. The four display digits and dot sit directly behind it; its outputs drive the display.

## Interface
- SYNC_STAGES, 2, depth of the switch synchronizer (≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- sw  in  9  raw switches: [8] A tens++, [7] A ones++, [6] B tens++, [5] B ones++, [4] sub, [3] div, [2] add, [1] mul, [0] show operands
- digit1  out  4  BCD, most significant display digit
- digit2  out  4  BCD
- digit3  out  4  BCD
- digit4  out  4  BCD, least significant
- dot  out  1  decimal point between digit2 and digit3
- neg  out  1  result is negative (sub only)
- err  out  1  divide by zero
- busy  out  1  arithmetic sequence in progress

## Operation
- sw passes through SYNC_STAGES flops; a rising edge is detected per bit on the synchronized value. A held switch yields exactly one event.
- Accept rule: events are accepted only in IDLE. Multiple same-cycle edges: highest index wins, others dropped. Edges while busy=1 are dropped, not queued.
- Operands: A={a1,a0}, B={b1,b0}, BCD, reset 0. Increment keys add 1 to one digit, wrapping 9→0 with no carry into the neighbour.
- Increment or show (sw[0]): operand mode, single cycle, no busy. Outputs: digits=a1,a0,b1,b0, dot=1, neg=0, err=0.
- Op keys start the FSM: IDLE→LOAD→EXEC→CONV→DONE→IDLE.
  - LOAD (1 cycle): A=10·a1+a0, B=10·b1+b0, 7-bit binary; op latched.
  - EXEC:
    - add/sub: 1 cycle. Sub: A≥B gives A−B, neg=0; else B−A, neg=1.
    - mul: 7 cycles, shift-add, 14-bit product (max 9801).
    - div: 7 cycles, restoring, quotient=floor(A/B), remainder discarded. B=0 sets err=1 and result 0.
  - CONV: 14 cycles, double-dabble of the 14-bit result to 4 BCD digits.
  - DONE (1 cycle): outputs registered. Result mode: dot=0, leading zeros shown (e.g. 0198).
- Outputs hold their previous values for the whole sequence. neg and err update only at DONE. Any accepted event clears err.

## Timing
- Reset values (async, immediate): digits 0, dot=1, neg=0, err=0, busy=0, FSM IDLE, operands 0, synchronizer cleared.
- Increment/show: outputs update on the clock after the accepted-edge clock.
- busy rises on the clock after the accepted-edge clock. It falls on the same clock edge that loads the result outputs.
- Latency from the accepted-edge clock to updated outputs:
  - add/sub: 17 clocks.
  - mul/div: 23 clocks.
  - Raw switch to accepted edge: SYNC_STAGES+1 clocks.
- Reset mid-sequence: abort, reset values at once, partial result discarded. After release the block is IDLE, showing 00.00.
- Edge arriving in the DONE cycle is dropped. Edge arriving in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset, then pulse sw[8], sw[7], sw[6], sw[5] nine times each (with gaps) → digits 9,9,9,9, dot=1. A tenth pulse of sw[5] → 99.90 (ones wrap, tens unchanged).
- A=B=99:
  - add → busy 17 clocks, then 0198, dot=0.
  - mul → 23 clocks, then 9801.
  - sub → 0000, neg=0.
  - div → 0001.
  - show → 99.99.
- A=32, B=98:
  - sub → 0066, neg=1.
  - div → 0000.
  - mul → 3136, neg=0.
- A=32, B=00: div → 0000, err=1. Then sw[0] → 32.00, err=0.
- Arbitration:
  - sw[8] and sw[2] rising in the same clock → only a1 increments, no busy.
  - sw[4] edge during a mul sequence → dropped; result 3136 and busy timing unchanged.
- Reset low during CONV of mul → busy=0, digits 0, dot=1 immediately. After release, show → 00.00.
